// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit
//   Sequencing FSM for a multi-cycle RV32I datapath. It decodes the IR
//   opcode and drives the datapath enables and mux selects for one
//   instruction at a time. It stalls on mem_ready, halts on the halt ecall,
//   and keeps the cycle and retired-instruction counters.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   opcode        IR[6:0]
//   bcond         ALU branch-condition result (used in BR)
//   x17           register x17 value (ecall halt test)
//   mem_ready     memory access completes this cycle
//   pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write
//                 datapath strobes / address select
//   wb_sel        rd data: 0=ALUOut 1=MDR 2=PC
//   alu_src_a     0=PC 1=A 2=oldPC
//   alu_src_b     0=B 1=imm 2=4
//   alu_op        0=add 1=branch compare 2=funct decode
//   pc_source     0=ALU result 1=ALUOut
//   is_halted     core halted
//   state         current state (debug)
//   cycle_count   cycles since reset, frozen while halted
//   instr_count   instructions retired
module multi_cycle_control_unit #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic                 bcond,
    input  logic [31:0]          x17,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           wb_sel,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 pc_source,
    output logic                 is_halted,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BR       = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    state_t r_state;
    state_t w_next;
    logic   w_retire;
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic [CNT_WIDTH-1:0] r_instr_count;

    // Next state plus a retire flag for the edge that completes an instruction.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        unique case (r_state)
            S_IF:       if (mem_ready) w_next = S_ID;
            S_ID: begin
                unique case (opcode)
                    OP_R:               w_next = S_EX_R;
                    OP_I:               w_next = S_EX_I;
                    OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
                    OP_BRANCH:          w_next = S_BR;
                    OP_JAL:             w_next = S_JAL;
                    OP_JALR:            w_next = S_JALR;
                    default: begin
                        // ecall (halting or not) and unknown opcodes retire here
                        w_retire = 1'b1;
                        if (opcode == OP_ECALL && x17 == HALT_CODE) w_next = S_HALT;
                        else                                        w_next = S_IF;
                    end
                endcase
            end
            S_EX_R, S_EX_I: w_next = S_WB_ALU;
            S_MEM_ADDR:     w_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:       if (mem_ready) w_next = S_WB_MEM;
            S_MEM_WR: begin
                if (mem_ready) begin
                    w_next   = S_IF;
                    w_retire = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BR, S_JAL, S_JALR: begin
                w_next   = S_IF;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IF;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state != S_HALT) r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            if (w_retire)          r_instr_count <= r_instr_count + CNT_WIDTH'(1);
        end
    end

    // Controls decode from the registered state; only the IF handshake
    // strobes and the branch pc_write are qualified by live inputs.
    // Everything is held at 0 during reset so no strobe escapes that cycle.
    always_comb begin
        pc_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        pc_source = 1'b0;
        is_halted = 1'b0;
        if (!reset) begin
            unique case (r_state)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd2;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID:       begin alu_src_a = 2'd2; alu_src_b = 2'd1; end
                S_EX_R:     begin alu_src_a = 2'd1; alu_op = 2'd2; end
                S_EX_I:     begin alu_src_a = 2'd1; alu_src_b = 2'd1; alu_op = 2'd2; end
                S_WB_ALU:   reg_write = 1'b1;
                S_MEM_ADDR: begin alu_src_a = 2'd1; alu_src_b = 2'd1; end
                S_MEM_RD:   begin mem_read = 1'b1; i_or_d = 1'b1; end
                S_WB_MEM:   begin reg_write = 1'b1; wb_sel = 2'd1; end
                S_MEM_WR:   begin mem_write = 1'b1; i_or_d = 1'b1; end
                S_BR: begin
                    alu_src_a = 2'd1;
                    alu_op    = 2'd1;
                    pc_source = 1'b1;
                    pc_write  = bcond;
                end
                S_JAL: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                    pc_write  = 1'b1;
                    pc_source = 1'b1;
                end
                S_JALR: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                end
                S_HALT:  is_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = r_state;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Testbench for multi_cycle_control_unit: per-cycle vector table with a
// scoreboard queue, followed by hand-written halt and reset sequences.
module tb_multi_cycle_control_unit;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;
    localparam logic [6:0] OP_BAD    = 7'b0000000;

    // Control word: {pc_write,i_or_d,mem_read,mem_write,ir_write,reg_write,
    //                wb_sel,alu_src_a,alu_src_b,alu_op,pc_source,is_halted}
    function automatic logic [15:0] mk(input logic pw, iod, mr, mw, irw, rw,
                                       input logic [1:0] wb, a, b, op,
                                       input logic ps, h);
        return {pw, iod, mr, mw, irw, rw, wb, a, b, op, ps, h};
    endfunction

    localparam logic [15:0] C_RST  = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    localparam logic [15:0] C_IF1  = mk(1,0,1,0,1,0, 2'd0,2'd0,2'd2,2'd0, 0,0);
    localparam logic [15:0] C_IF0  = mk(0,0,1,0,0,0, 2'd0,2'd0,2'd2,2'd0, 0,0);
    localparam logic [15:0] C_ID   = mk(0,0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0, 0,0);
    localparam logic [15:0] C_EXR  = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd2, 0,0);
    localparam logic [15:0] C_EXI  = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd2, 0,0);
    localparam logic [15:0] C_WBA  = mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 0,0);
    localparam logic [15:0] C_MA   = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0, 0,0);
    localparam logic [15:0] C_MRD  = mk(0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    localparam logic [15:0] C_WBM  = mk(0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0, 0,0);
    localparam logic [15:0] C_MWR  = mk(0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0,0);
    localparam logic [15:0] C_BR1  = mk(1,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd1, 1,0);
    localparam logic [15:0] C_BR0  = mk(0,0,0,0,0,0, 2'd0,2'd1,2'd0,2'd1, 1,0);
    localparam logic [15:0] C_JAL  = mk(1,0,0,0,0,1, 2'd2,2'd0,2'd0,2'd0, 1,0);
    localparam logic [15:0] C_JALR = mk(1,0,0,0,0,1, 2'd2,2'd1,2'd1,2'd0, 0,0);
    localparam logic [15:0] C_HALT = mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0,1);

    typedef struct {
        logic        rst;
        logic [6:0]  opc;
        logic        bc;
        logic [31:0] x;
        logic        rdy;
        logic [3:0]  st;    // expected state during this cycle
        logic [15:0] ctl;   // expected control word during this cycle
        logic        ret;   // this cycle's edge retires an instruction
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        bcond;
    logic [31:0] x17;
    logic        mem_ready;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  wb_sel, alu_src_a, alu_src_b, alu_op;
    logic        pc_source, is_halted;
    logic [3:0]  state;
    logic [31:0] cycle_count, instr_count;

    always #5 clk = ~clk;

    multi_cycle_control_unit #(.HALT_CODE(32'd10), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17(x17),
        .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .is_halted(is_halted), .state(state), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    wire [15:0] ctl_act = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
                           wb_sel, alu_src_a, alu_src_b, alu_op, pc_source, is_halted};

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ins = '0;
    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [6:0] opc, input logic bc,
                       input logic [31:0] x, input logic rdy, input logic [3:0] st,
                       input logic [15:0] ctl, input logic ret);
        vec_t v;
        v.rst = rst; v.opc = opc; v.bc = bc; v.x = x; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.ret = ret;
        tbl.push_back(v);
    endtask

    initial begin
        vec_t e;
        // add x3,x1,x2
        add(0, OP_R, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_R, 0, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_R, 0, 0, 1, 4'd2, C_EXR, 0);
        add(0, OP_R, 0, 0, 1, 4'd7, C_WBA, 1);
        // lw with 3 wait cycles in MEM_RD; mem_ready toggles ignored in ID/MEM_ADDR
        add(0, OP_LOAD, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_LOAD, 0, 0, 0, 4'd1, C_ID,  0);
        add(0, OP_LOAD, 0, 0, 1, 4'd4, C_MA,  0);
        add(0, OP_LOAD, 0, 0, 0, 4'd5, C_MRD, 0);
        add(0, OP_LOAD, 0, 0, 0, 4'd5, C_MRD, 0);
        add(0, OP_LOAD, 0, 0, 0, 4'd5, C_MRD, 0);
        add(0, OP_LOAD, 0, 0, 1, 4'd5, C_MRD, 0);
        add(0, OP_LOAD, 0, 0, 1, 4'd8, C_WBM, 1);
        // sw with fetch stall and one write wait
        add(0, OP_STORE, 0, 0, 0, 4'd0, C_IF0, 0);
        add(0, OP_STORE, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_STORE, 0, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_STORE, 0, 0, 1, 4'd4, C_MA,  0);
        add(0, OP_STORE, 0, 0, 0, 4'd6, C_MWR, 0);
        add(0, OP_STORE, 0, 0, 1, 4'd6, C_MWR, 1);
        // beq taken, then not taken
        add(0, OP_BRANCH, 1, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_BRANCH, 1, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_BRANCH, 1, 0, 1, 4'd9, C_BR1, 1);
        add(0, OP_BRANCH, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_BRANCH, 0, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_BRANCH, 0, 0, 1, 4'd9, C_BR0, 1);
        // jal, jalr
        add(0, OP_JAL,  0, 0, 1, 4'd0,  C_IF1,  0);
        add(0, OP_JAL,  0, 0, 1, 4'd1,  C_ID,   0);
        add(0, OP_JAL,  0, 0, 1, 4'd10, C_JAL,  1);
        add(0, OP_JALR, 0, 0, 1, 4'd0,  C_IF1,  0);
        add(0, OP_JALR, 0, 0, 1, 4'd1,  C_ID,   0);
        add(0, OP_JALR, 0, 0, 1, 4'd11, C_JALR, 1);
        // addi
        add(0, OP_I, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_I, 0, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_I, 0, 0, 1, 4'd3, C_EXI, 0);
        add(0, OP_I, 0, 0, 1, 4'd7, C_WBA, 1);
        // unknown opcode and non-halting ecall retire as NOPs from ID
        add(0, OP_BAD,   0, 0,     1, 4'd0, C_IF1, 0);
        add(0, OP_BAD,   0, 0,     1, 4'd1, C_ID,  1);
        add(0, OP_ECALL, 0, 32'd5, 1, 4'd0, C_IF1, 0);
        add(0, OP_ECALL, 0, 32'd5, 1, 4'd1, C_ID,  1);
        // reset while MEM_WR waits: no write strobe in the reset cycle
        add(0, OP_STORE, 0, 0, 1, 4'd0, C_IF1, 0);
        add(0, OP_STORE, 0, 0, 1, 4'd1, C_ID,  0);
        add(0, OP_STORE, 0, 0, 1, 4'd4, C_MA,  0);
        add(0, OP_STORE, 0, 0, 0, 4'd6, C_MWR, 0);
        add(1, OP_STORE, 0, 0, 0, 4'd6, C_RST, 0);
        // halting ecall
        add(0, OP_ECALL, 0, 32'd10, 1, 4'd0, C_IF1, 0);
        add(0, OP_ECALL, 0, 32'd10, 1, 4'd1, C_ID,  1);

        reset = 1'b1; opcode = OP_R; bcond = 1'b0; x17 = '0; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("reset_state", -1, 32'(state), 32'd0);
        chk("reset_ctl",   -1, 32'(ctl_act), 32'(C_RST));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; opcode = tbl[i].opc; bcond = tbl[i].bc;
            x17 = tbl[i].x; mem_ready = tbl[i].rdy;
            sb.push_back(tbl[i]);
            #1;
            e = sb.pop_front();
            chk("state", i, 32'(state), 32'(e.st));
            chk("ctl",   i, 32'(ctl_act), 32'(e.ctl));
            chk("cycle_count", i, cycle_count, m_cyc);
            chk("instr_count", i, instr_count, m_ins);
            if (e.rst) begin
                m_cyc = '0;
                m_ins = '0;
            end else begin
                if (e.st != 4'd12) m_cyc = m_cyc + 1;
                if (e.ret)         m_ins = m_ins + 1;
            end
        end

        // Halted: terminal with frozen counters regardless of inputs.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            bcond     = 1'($urandom_range(0, 1));
            opcode    = (k % 2 == 0) ? OP_STORE : OP_R;
            #1;
            chk("halt_state", k, 32'(state), 32'd12);
            chk("halt_ctl",   k, 32'(ctl_act), 32'(C_HALT));
            chk("halt_cycle", k, cycle_count, m_cyc);
            chk("halt_instr", k, instr_count, m_ins);
        end

        // Only reset leaves HALT.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0; #1;
        chk("unhalt_state", 0, 32'(state), 32'd0);
        chk("unhalt_ctl",   0, 32'(ctl_act), 32'(C_IF0));
        chk("unhalt_cycle", 0, cycle_count, 32'd0);
        chk("unhalt_instr", 0, instr_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
- Moore-style FSM with a few Mealy-qualified strobes; sequences the multi-cycle RV32I datapath (register file, shared instruction/data memory, ALU, PC, IR/MDR/A/B/ALUOut latches).
- Decodes the IR opcode and drives every datapath enable and mux select for one instruction at a time.
- Stalls on a memory-ready handshake, detects the halt ecall, and keeps cycle and retired-instruction counters.

Parameters:
- HALT_CODE, 32'd10, x17 value that makes ECALL halt the core.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  input  1  clock.
- reset  input  1  reset.
- opcode  input  7  IR[6:0].
- bcond  input  1  ALU branch-condition result, valid in BR.
- x17  input  32  register x17 value from the register file.
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  PC load enable.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR and old-PC latch enable.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  rd data select: 0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  output  2  ALU A select: 0=PC, 1=A(rs1), 2=oldPC.
- alu_src_b  output  2  ALU B select: 0=B(rs2), 1=imm, 2=const 4.
- alu_op  output  2  ALU op class: 0=add, 1=branch compare, 2=funct decode.
- pc_source  output  1  PC source: 0=ALU result, 1=ALUOut.
- is_halted  output  1  core halted.
- state  output  4  current state, for debug.
- cycle_count  output  CNT_WIDTH  cycles since reset.
- instr_count  output  CNT_WIDTH  instructions retired.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. State IF(0). Counters 0, is_halted 0. All strobes (pc_write, mem_read, mem_write, ir_write, reg_write) are forced to 0 while reset=1. Selects default to 0.
- States: IF=0, ID=1, EX_R=2, EX_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BR=9, JAL=10, JALR=11, HALT=12.
- Opcodes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, ECALL=1110011.
- IF:
  - Drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=2, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready.
  - Remain in IF until mem_ready, then go to ID.
- ID:
  - Drive alu_src_a=2, alu_src_b=1, alu_op=0, so ALUOut latches the branch/JAL target.
  - Next state by opcode: R->EX_R, I->EX_I, LOAD/STORE->MEM_ADDR, BRANCH->BR, JAL->JAL, JALR->JALR.
  - ECALL goes to HALT if x17==HALT_CODE, else to IF and retires as a NOP.
  - Unknown opcode goes to IF and retires as a NOP.
- EX_R: a=1, b=0, op=2, then WB_ALU.
- EX_I: a=1, b=1, op=2, then WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0, then IF (retire).
- MEM_ADDR: a=1, b=1, op=0, then MEM_RD for LOAD or MEM_WR for STORE.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready (MDR latches that cycle), then WB_MEM.
- WB_MEM: reg_write=1, wb_sel=1, then IF (retire).
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then IF (retire).
- BR: a=1, b=0, op=1, pc_source=1, pc_write=bcond, then IF (retire).
- JAL: reg_write=1, wb_sel=2 (PC already holds PC+4), pc_write=1, pc_source=1, then IF (retire).
- JALR:
  - Drive a=1, b=1, op=0, pc_source=0, pc_write=1, reg_write=1, wb_sel=2, then IF (retire).
  - rd receives the pre-edge PC (PC+4).
  - The datapath clears bit 0 of the target.
- HALT: is_halted=1, all strobes 0. Terminal until reset.
- cycle_count: +1 every non-reset cycle while not halted; wraps modulo 2^CNT_WIDTH.
- instr_count: +1 on every edge transitioning into IF from a retiring state, and on an ECALL that does not halt. The halting ECALL also counts, on its transition to HALT.
- mem_ready outside IF/MEM_RD/MEM_WR is ignored.
- Reset mid-access (IF/MEM_RD/MEM_WR): state returns to IF on the next edge. No write strobe is issued in the reset cycle.

Test Plan:
- add x3,x1,x2 with mem_ready=1 always -> states 0,1,2,7,0. reg_write high only in WB_ALU. instr_count=1 after 4 cycles.
- lw with mem_ready low 3 cycles in MEM_RD -> state 5 held 4 cycles, then 8 with reg_write=1 and wb_sel=1. cycle_count advances 8 in total.
- beq with bcond=1, then beq with bcond=0 -> pc_write=1 with pc_source=1 in BR for the first; pc_write=0 for the second; both return to IF.
- jal, then jalr -> JAL asserts reg_write, pc_write, wb_sel=2, pc_source=1. JALR asserts the same with pc_source=0.
- ecall with x17=5, then ecall with x17=10 -> first returns to IF with instr_count +1. Second enters HALT: is_halted=1, counters frozen, strobes 0 for 20 cycles.
- reset asserted during MEM_WR with mem_ready=0 -> next cycle state=0, mem_write=0, counters=0, is_halted=0.
